// File: rtl/tdm_slot_sequencer.sv
// TDM slot sequencer: walks the enabled channels of one latched frame in ascending
// order, driving the demux select lines and data word, and parks data at all-ones otherwise.
module tdm_slot_sequencer #(
    parameter int SLOT_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iValid,
    output logic       oReady,
    input  logic [7:0] iData,
    input  logic [7:0] iMask,
    input  logic       iAbort,
    output logic [7:0] oData,
    output logic       oA,
    output logic       oB,
    output logic       oC,
    output logic       oBusy,
    output logic       oDone
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t           state_q;
    logic [7:0]       frame_q;
    logic [7:0]       mask_q;
    logic [2:0]       ch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       data_q;
    logic [2:0]       sel_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       first_s;
    logic [3:0]       next_s;

    // Returns {found, index} of the lowest set mask bit at or above start.
    function automatic logic [3:0] lowest_from(input logic [7:0] mask, input logic [3:0] start);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    // Channel search for the accepting edge and for the next-slot decision.
    always_comb begin
        first_s = lowest_from(iMask, 4'd0);
        next_s  = lowest_from(mask_q, {1'b0, ch_q} + 4'd1);
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            frame_q <= 8'h00;
            mask_q  <= 8'h00;
            ch_q    <= 3'd0;
            cnt_q   <= '0;
            data_q  <= 8'hFF;
            sel_q   <= 3'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (iAbort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'hFF;
            sel_q   <= 3'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iValid) begin
                        frame_q <= iData;
                        mask_q  <= iMask;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (first_s[3]) begin
                            state_q <= ST_SLOT;
                            ch_q    <= first_s[2:0];
                            sel_q   <= first_s[2:0];
                            cnt_q   <= SLOT_LOAD;
                            data_q  <= iData;
                        end else begin
                            state_q <= ST_DONE;
                            ch_q    <= 3'd0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SLOT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (GAP_CYCLES > 0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                        data_q  <= 8'hFF;
                    end else if (next_s[3]) begin
                        ch_q   <= next_s[2:0];
                        sel_q  <= next_s[2:0];
                        cnt_q  <= SLOT_LOAD;
                    end else begin
                        state_q <= ST_DONE;
                        data_q  <= 8'hFF;
                        sel_q   <= 3'd0;
                        done_q  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (next_s[3]) begin
                        state_q <= ST_SLOT;
                        ch_q    <= next_s[2:0];
                        sel_q   <= next_s[2:0];
                        cnt_q   <= SLOT_LOAD;
                        data_q  <= frame_q;
                    end else begin
                        state_q <= ST_DONE;
                        sel_q   <= 3'd0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    data_q  <= 8'hFF;
                    sel_q   <= 3'd0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oReady = ready_q;
    assign oData  = data_q;
    assign oA     = sel_q[2];
    assign oB     = sel_q[1];
    assign oC     = sel_q[0];
    assign oBusy  = busy_q;
    assign oDone  = done_q;

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Randomised bench for tdm_slot_sequencer: per-cycle outputs compared against a
// frame-level model that expands each accepted word into its expected cycle list.
module tb_tdm_slot_sequencer;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic       rdy;
        logic       busy;
        logic       done;
    } obs_t;

    localparam obs_t IDLE_E = '{d: 8'hFF, s: 3'd0, rdy: 1'b1, busy: 1'b0, done: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       v1 = 1'b0, v2 = 1'b0, ab1 = 1'b0, ab2 = 1'b0;
    logic [7:0] d1 = 8'h00, m1 = 8'h00, d2 = 8'h00, m2 = 8'h00;
    logic       rdy1, busy1, done1, a1, b1, c1;
    logic       rdy2, busy2, done2, a2, b2, c2;
    logic [7:0] od1, od2;

    int checks = 0;
    int failures = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    tdm_slot_sequencer dut1 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v1), .oReady(rdy1), .iData(d1), .iMask(m1),
        .iAbort(ab1), .oData(od1), .oA(a1), .oB(b1), .oC(c1), .oBusy(busy1), .oDone(done1)
    );

    tdm_slot_sequencer #(.SLOT_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut2 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v2), .oReady(rdy2), .iData(d2), .iMask(m2),
        .iAbort(ab2), .oData(od2), .oA(a2), .oB(b2), .oC(c2), .oBusy(busy2), .oDone(done2)
    );

    function automatic obs_t read(input int which);
        obs_t o;
        if (which == 1) o = '{d: od1, s: {a1, b1, c1}, rdy: rdy1, busy: busy1, done: done1};
        else            o = '{d: od2, s: {a2, b2, c2}, rdy: rdy2, busy: busy2, done: done2};
        return o;
    endfunction

    task automatic sample(input int which, output obs_t o);
        @(negedge clk);
        o = read(which);
    endtask

    // Expands one frame into its expected cycle list: slots and gaps per enabled
    // channel in ascending order, one done cycle, then the idle cycle that follows.
    task automatic build(input logic [7:0] d, input logic [7:0] m, input int S, input int G);
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch]) begin
                repeat (S) exp_q.push_back('{d: d, s: 3'(ch), rdy: 1'b0, busy: 1'b1, done: 1'b0});
                repeat (G) exp_q.push_back('{d: 8'hFF, s: 3'(ch), rdy: 1'b0, busy: 1'b1, done: 1'b0});
            end
        end
        exp_q.push_back('{d: 8'hFF, s: 3'd0, rdy: 1'b0, busy: 1'b1, done: 1'b1});
        exp_q.push_back(IDLE_E);
    endtask

    // Offers a word at a negedge, lets one edge accept it, then scrambles the inputs.
    task automatic start(input int which, input logic [7:0] d, input logic [7:0] m,
                         input bit hold, input logic [7:0] nd, input logic [7:0] nm);
        if (which == 1) begin v1 = 1'b1; d1 = d; m1 = m; end
        else            begin v2 = 1'b1; d2 = d; m2 = m; end
        @(posedge clk);
        #1;
        if (which == 1) begin v1 = hold; d1 = nd; m1 = nm; end
        else            begin v2 = hold; d2 = nd; m2 = nm; end
    endtask

    task automatic test_reset();
        obs_t o;
        #2 rst_n = 1'b0;
        #1;
        o = read(1);
        checks++;
        if (o !== IDLE_E) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, IDLE_E); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        sample(2, o);
        checks++;
        if (o !== IDLE_E) begin failures++; $display("FAIL reset_release got=%h exp=%h", o, IDLE_E); end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic [7:0] m, input int abort_at);
        obs_t o, e;
        int lim;
        exp_q.delete();
        build(d, m, 4, 1);
        lim = (abort_at > 0) ? abort_at + 3 : exp_q.size();
        start(1, d, m, 1'b0, $urandom, $urandom);
        for (int k = 1; k <= lim; k++) begin
            sample(1, o);
            e = (abort_at > 0 && k > abort_at) ? IDLE_E : exp_q[k-1];
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, o, e); end
            if (k == abort_at) ab1 = 1'b1;
            if (k == abort_at + 1) ab1 = 1'b0;
        end
    endtask

    task automatic test_directed();
        test_frame("frame_85_A5", 8'hA5, 8'h85, 0);
        test_frame("mask_zero", 8'h5A, 8'h00, 0);
        test_frame("abort_cyc7", 8'hA5, 8'h85, 7);
        test_frame("after_abort", 8'hC3, 8'h42, 0);
        test_frame("mask_top_only", 8'h11, 8'h80, 0);
    endtask

    task automatic test_random();
        logic [7:0] d, m;
        int ab;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            m = 8'($urandom);
            exp_q.delete();
            build(d, m, 4, 1);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, exp_q.size() - 1)) : 0;
            test_frame("random_frame", d, m, ab);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int s1;
        exp_q.delete();
        build(8'h96, 8'h09, 4, 1);
        s1 = exp_q.size();
        build(8'h3E, 8'h50, 4, 1);
        start(1, 8'h96, 8'h09, 1'b1, 8'h3E, 8'h50);
        for (int k = 1; k <= exp_q.size(); k++) begin
            sample(1, o);
            checks++;
            if (o !== exp_q[k-1]) begin failures++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", k, o, exp_q[k-1]); end
            if (k == s1 + 1) v1 = 1'b0;
        end
    endtask

    task automatic test_gapless();
        obs_t o;
        logic [7:0] d, m;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 8'h3C : 8'($urandom);
            m = (n == 0) ? 8'hFF : 8'($urandom);
            exp_q.delete();
            build(d, m, 1, 0);
            start(2, d, m, 1'b0, $urandom, $urandom);
            for (int k = 1; k <= exp_q.size(); k++) begin
                sample(2, o);
                checks++;
                if (o !== exp_q[k-1]) begin failures++; $display("FAIL gapless cyc=%0d got=%h exp=%h", k, o, exp_q[k-1]); end
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        exp_q.delete();
        build(8'hA5, 8'h85, 4, 1);
        start(1, 8'hA5, 8'h85, 1'b0, 8'h00, 8'h00);
        for (int k = 1; k <= 2; k++) begin
            sample(1, o);
            checks++;
            if (o !== exp_q[k-1]) begin failures++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", k, o, exp_q[k-1]); end
        end
        #2 rst_n = 1'b0;
        #1;
        o = read(1);
        checks++;
        if (o !== IDLE_E) begin failures++; $display("FAIL async_reset got=%h exp=%h", o, IDLE_E); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            sample(1, o);
            checks++;
            if (o !== IDLE_E) begin failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", k, o, IDLE_E); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_gapless();
        test_async_reset();
        test_frame("after_reset", 8'h77, 8'h24, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
